// File: rtl/branch_fetch_pc_pkg.sv
// Shared fetch-PC constants and the next-PC select encoding used by the fetch,
// decode and pattern-history neighbours.
package branch_fetch_pc_pkg;
    localparam int          PC_W      = 16;
    localparam int          BTB_IDX_W = 6;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int          BTB_TAG_W = PC_W - BTB_IDX_W - 2;

    localparam logic [1:0] NPC_REDIRECT = 2'd0;
    localparam logic [1:0] NPC_HOLD     = 2'd1;
    localparam logic [1:0] NPC_TARGET   = 2'd2;
    localparam logic [1:0] NPC_SEQ      = 2'd3;

    // Redirect beats stall, stall beats a predicted-taken branch.
    function automatic logic [1:0] npc_select(input logic redirect,
                                              input logic stall,
                                              input logic pred_taken);
        if (redirect)        return NPC_REDIRECT;
        else if (stall)      return NPC_HOLD;
        else if (pred_taken) return NPC_TARGET;
        else                 return NPC_SEQ;
    endfunction
endpackage

// File: rtl/branch_fetch_pc_if.sv
// Fetch-stage bus: control/update inputs from execute and the PHT, and the
// fetch PC with its BTB lookup results.
interface branch_fetch_pc_if #(parameter int PC_W = branch_fetch_pc_pkg::PC_W);
    logic            stall;
    logic            pht_taken;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic [PC_W-1:0] pc;
    logic            btb_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            flush;

    modport master (
        output stall, pht_taken, redirect_valid, redirect_pc,
               upd_valid, upd_pc, upd_target, upd_taken,
        input  pc, btb_hit, pred_taken, pred_target, flush
    );

    modport slave (
        input  stall, pht_taken, redirect_valid, redirect_pc,
               upd_valid, upd_pc, upd_target, upd_taken,
        output pc, btb_hit, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/branch_fetch_pc_btb_table.sv
// Direct-mapped BTB: async-cleared valid bits, one combinational lookup port
// and one synchronous write/invalidate port.
module btb_table
    import branch_fetch_pc_pkg::*;
#(
    parameter int PC_W_P  = branch_fetch_pc_pkg::PC_W,
    parameter int IDX_W_P = branch_fetch_pc_pkg::BTB_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W_P-1:2] rd_pc,
    output logic              rd_hit,
    output logic [PC_W_P-1:0] rd_target,
    input  logic              wr_valid,
    input  logic [PC_W_P-1:2] wr_pc,
    input  logic [PC_W_P-1:0] wr_target,
    input  logic              wr_taken
);
    localparam int TAG_W   = PC_W_P - IDX_W_P - 2;
    localparam int ENTRIES = 1 << IDX_W_P;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [PC_W_P-1:0]  tgt_mem [ENTRIES];

    logic [IDX_W_P-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]   rd_tag, wr_tag;
    logic               wr_hit;

    assign rd_idx = rd_pc[IDX_W_P+1:2];
    assign rd_tag = rd_pc[PC_W_P-1:IDX_W_P+2];
    assign wr_idx = wr_pc[IDX_W_P+1:2];
    assign wr_tag = wr_pc[PC_W_P-1:IDX_W_P+2];

    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target = rd_hit ? tgt_mem[rd_idx] : '0;
    assign wr_hit    = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_valid) begin
            if (wr_taken)     valid[wr_idx] <= 1'b1;
            else if (wr_hit)  valid[wr_idx] <= 1'b0;  // drop never-taken branch
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_valid && wr_taken) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end
endmodule

// File: rtl/branch_fetch_pc.sv
// Fetch PC register with redirect/stall/predicted/sequential next-PC mux,
// redirect flush flop and the BTB it looks up each cycle.
module branch_fetch_pc
    import branch_fetch_pc_pkg::*;
#(
    parameter int                           PC_W_P    = branch_fetch_pc_pkg::PC_W,
    parameter int                           IDX_W_P   = branch_fetch_pc_pkg::BTB_IDX_W,
    parameter logic [PC_W_P-1:0]            RST_PC_P  = PC_W_P'(branch_fetch_pc_pkg::RESET_PC)
) (
    input  logic           clk,
    input  logic           rst,
    branch_fetch_pc_if.slave bus
);
    logic [PC_W_P-1:0] pc_q;
    logic              flush_q;
    logic              hit;
    logic [PC_W_P-1:0] target;
    logic              pred_taken;
    logic [1:0]        sel;

    btb_table #(.PC_W_P(PC_W_P), .IDX_W_P(IDX_W_P)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (pc_q[PC_W_P-1:2]),
        .rd_hit    (hit),
        .rd_target (target),
        .wr_valid  (bus.upd_valid),
        .wr_pc     (bus.upd_pc[PC_W_P-1:2]),
        .wr_target (bus.upd_target),
        .wr_taken  (bus.upd_taken)
    );

    assign pred_taken = bus.pht_taken & hit;
    assign sel        = npc_select(bus.redirect_valid, bus.stall, pred_taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RST_PC_P;
            flush_q <= 1'b0;
        end else begin
            flush_q <= bus.redirect_valid;
            case (sel)
                NPC_REDIRECT: pc_q <= {bus.redirect_pc[PC_W_P-1:2], 2'b00};
                NPC_HOLD:     pc_q <= pc_q;
                NPC_TARGET:   pc_q <= {target[PC_W_P-1:2], 2'b00};
                default:      pc_q <= pc_q + PC_W_P'(4);
            endcase
        end
    end

    // Byte-offset bits of incoming addresses are ignored; fetch is word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.redirect_pc[1:0], bus.upd_pc[1:0]};

    assign bus.pc          = pc_q;
    assign bus.btb_hit     = hit;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = target;
    assign bus.flush       = flush_q;
endmodule

// File: tb/tb_branch_fetch_pc.sv
// Directed bench for branch_fetch_pc: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_fetch_pc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_fetch_pc_if #(.PC_W(16)) bus ();

    branch_fetch_pc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       nm;
        logic [15:0] pc;
        logic        hit;
        logic        pt;
        logic [15:0] tgt;
        logic        fl;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Apply one cycle of inputs, record what the outputs must be during it,
    // then advance to just after the next rising edge.
    task automatic step(input string nm, input logic s, input logic ph,
                        input logic rv, input logic [15:0] rpc,
                        input logic uv, input logic [15:0] upc,
                        input logic [15:0] utg, input logic utk,
                        input logic [15:0] epc, input logic eh,
                        input logic [15:0] etg, input logic ef);
        exp_t e;
        bus.stall          = s;
        bus.pht_taken      = ph;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_target     = utg;
        bus.upd_taken      = utk;
        e.nm  = nm;
        e.pc  = epc;
        e.hit = eh;
        e.pt  = ph & eh;
        e.tgt = etg;
        e.fl  = ef;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.btb_hit !== e.hit || bus.pred_taken !== e.pt ||
                bus.pred_target !== e.tgt || bus.flush !== e.fl) begin
                errors++;
                $display("FAIL %s: got pc=%h hit=%b pt=%b tgt=%h flush=%b, want pc=%h hit=%b pt=%b tgt=%h flush=%b",
                         e.nm, bus.pc, bus.btb_hit, bus.pred_taken, bus.pred_target, bus.flush,
                         e.pc, e.hit, e.pt, e.tgt, e.fl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.stall = 0; bus.pht_taken = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_target = 0; bus.upd_taken = 0;
        @(posedge clk); #1;
        // update presented while in reset must be lost
        step("reset",      0,0, 0,16'h0000, 1,16'h0040,16'h0500,1, 16'h0000,0,16'h0000,0);
        rst = 1'b1;
        step("seq0",       0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0000,0,16'h0000,0);
        step("seq4",       0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0004,0,16'h0000,0);
        step("seq8",       0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0008,0,16'h0000,0);
        step("seqC_upd",   0,0, 0,16'h0000, 1,16'h0010,16'h0100,1, 16'h000C,0,16'h0000,0);
        step("hit_taken",  0,1, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0010,1,16'h0100,0);
        step("at_target",  0,0, 1,16'h0000, 0,16'h0000,16'h0000,0, 16'h0100,0,16'h0000,0);
        step("redir0",     0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0000,0,16'h0000,1);
        step("rerun4",     0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0004,0,16'h0000,0);
        step("rerun8",     0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0008,0,16'h0000,0);
        step("rerunC",     0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h000C,0,16'h0000,0);
        step("hit_ntaken", 0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0010,1,16'h0100,0);
        step("stall_redir",1,0, 1,16'h0203, 0,16'h0000,16'h0000,0, 16'h0014,0,16'h0000,0);
        step("redir200",   1,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0200,0,16'h0000,1);
        step("hold1",      1,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0200,0,16'h0000,0);
        step("hold2",      1,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0200,0,16'h0000,0);
        step("hold3",      0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0200,0,16'h0000,0);
        step("alias_upd",  0,0, 1,16'h0010, 1,16'h1010,16'h0200,1, 16'h0204,0,16'h0000,0);
        step("alias_miss", 0,1, 1,16'h1010, 0,16'h0000,16'h0000,0, 16'h0010,0,16'h0000,1);
        step("alias_hit",  0,1, 1,16'h1010, 1,16'h1010,16'h0000,0, 16'h1010,1,16'h0200,1);
        step("evicted",    0,1, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h1010,0,16'h0000,1);
        step("after_evict",0,0, 1,16'h0020, 0,16'h0000,16'h0000,0, 16'h1014,0,16'h0000,0);
        step("war_lookup", 0,1, 0,16'h0000, 1,16'h0020,16'h0300,1, 16'h0020,0,16'h0000,1);
        step("war_next",   0,0, 1,16'h0020, 0,16'h0000,16'h0000,0, 16'h0024,0,16'h0000,0);
        step("war_revisit",0,1, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0020,1,16'h0300,1);
        step("tgt300",     0,0, 1,16'hFFFC, 0,16'h0000,16'h0000,0, 16'h0300,0,16'h0000,0);
        step("wrap_fffc",  0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'hFFFC,0,16'h0000,1);
        step("wrap_0000",  0,0, 1,16'h0020, 0,16'h0000,16'h0000,0, 16'h0000,0,16'h0000,0);
        step("pre_rst_hit",0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0020,1,16'h0300,1);
        rst = 1'b0;  // asynchronous, mid-cycle
        step("async_rst",  0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0000,0,16'h0000,0);
        rst = 1'b1;
        step("post_rst",   0,0, 1,16'h0020, 0,16'h0000,16'h0000,0, 16'h0000,0,16'h0000,0);
        step("cleared",    0,1, 1,16'h0040, 0,16'h0000,16'h0000,0, 16'h0020,0,16'h0000,1);
        step("rst_upd_lost",0,1,0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0040,0,16'h0000,1);
        step("final_seq",  0,0, 0,16'h0000, 0,16'h0000,16'h0000,0, 16'h0044,0,16'h0000,0);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_fetch_pc.md
Name: branch_fetch_pc

Overview:
- Fetch-stage PC generator and branch target buffer (BTB).
- Drives the fetch PC into the pattern history table and instruction memory, and consumes the table's taken prediction for that same PC.
- Selects the next PC from: execute-stage redirect, stall hold, predicted-taken BTB target, or sequential PC+4.
- The BTB is updated from resolved branches in execute.

Parameters:
- PC_W, 16, PC and target width.
- BTB_IDX_W, 6, log2 of BTB entries (64 entries).
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-low reset.
- stall in 1: hold the fetch PC this cycle.
- pht_taken in 1: taken prediction for the current pc, from the pattern history table (combinational).
- redirect_valid in 1: execute detected a mispredict.
- redirect_pc in PC_W: correct fetch address.
- upd_valid in 1: resolved-branch update strobe.
- upd_pc in PC_W: PC of the resolved branch.
- upd_target in PC_W: resolved target.
- upd_taken in 1: branch was taken.
- pc out PC_W: current fetch PC (registered).
- btb_hit out 1: BTB has a valid, tag-matching entry for pc.
- pred_taken out 1: pht_taken AND btb_hit.
- pred_target out PC_W: BTB target for pc; 0 when btb_hit=0.
- flush out 1: registered one-cycle pulse after a redirect is accepted.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, flush=0, all BTB valid bits cleared.
  - Tag and target arrays are not reset.
  - Combinational outputs follow from the cleared valids: btb_hit=0, pred_taken=0, pred_target=0.
  - Reset deasserted mid-operation restarts fetch at RESET_PC.
  - Any redirect or update presented in the reset cycle is lost.
- BTB lookup (combinational on pc):
  - index = pc[BTB_IDX_W+1:2].
  - tag = pc[PC_W-1:BTB_IDX_W+2], 8 bits at the defaults.
  - hit = valid[index] AND tag match.
- Next-PC priority, registered on the clk edge:
  1. redirect_valid: pc <= {redirect_pc[PC_W-1:2],2'b00}. Overrides stall.
  2. stall: pc holds.
  3. pred_taken: pc <= {pred_target[PC_W-1:2],2'b00}.
  4. Otherwise: pc <= pc+4, wrapping modulo 2^PC_W (16'hFFFC -> 16'h0000).
- flush <= redirect_valid every cycle, so back-to-back redirects give a continuous flush.
- BTB update on the clk edge when upd_valid=1:
  - upd_taken=1: entry[upd index] <= {valid=1, upd tag, upd_target}, replacing any prior occupant (direct-mapped, no associativity).
  - upd_taken=0 and the entry hits on the upd tag: valid <= 0 (evict never-taken branches).
  - upd_taken=0 and the entry misses: no change.
- Update and lookup on the same index in the same cycle:
  - The lookup sees the old contents (write-after-read).
  - The new entry is visible from the next cycle.
- An update is applied regardless of stall or redirect.
- Redirect and pred_taken in the same cycle: redirect wins. BTB contents are unaffected by the choice of next PC.
- Latency: pc changes one cycle after the selecting condition. Lookup outputs are valid in the same cycle as pc.
- pred_target and btb_hit are purely combinational. No handshake beyond stall.

Decomposition:
- Shared package/header holds:
  - PC_W, BTB_IDX_W, RESET_PC defaults.
  - BTB_TAG_W = PC_W-BTB_IDX_W-2.
  - The next-PC select encoding (`NPC_REDIRECT`, `NPC_HOLD`, `NPC_TARGET`, `NPC_SEQ`), reused by decode and the pattern history table's neighbours.
- One sub-module is natural: btb_table.
  - Direct-mapped storage with async-cleared valid bits.
  - One combinational read port and one synchronous write/invalidate port.
- The top module holds the PC register, priority mux and flush flop.

Test Plan:
- Reset -> pc=16'h0000, flush=0, btb_hit=0. Then 3 free-running cycles -> pc 0004, 0008, 000C.
- Update upd_pc=16'h0010, upd_target=16'h0100, upd_taken=1; run from 0 with pht_taken=1 -> at pc=0010 btb_hit=1, pred_target=0100; next pc=0100. Same run with pht_taken=0 -> next pc=0014.
- stall=1 and redirect_valid=1 with redirect_pc=16'h0203 in the same cycle -> next pc=0200, flush=1 for exactly one cycle. stall=1 alone -> pc held over 3 cycles.
- Aliasing: taken update for 16'h0010, then taken update for 16'h1010 (same index, different tag) -> at pc=0010 btb_hit=0; at pc=1010 btb_hit=1. Not-taken update for 16'h1010 -> entry invalidated, btb_hit=0.
- Same-cycle update and lookup at pc=0020 -> btb_hit=0 that cycle; pc=0020 revisited later -> btb_hit=1. Wrap test: redirect to FFFC, no branch -> next pc=0000.
- Assert rst=0 asynchronously mid-run with valid entries present -> pc=0000 immediately (no clock edge needed), all previously valid entries miss.
